hub75_rx: RTL

- Panel-side receiver for the HUB75 interface, oversampling the bus from the system clock.
- Captures the shifted RGB columns on each LAT and measures how long OE is held active.
- Infers the bit-plane index and emits one "line event" per display interval through a valid/ready port.
- Used as an in-system loopback monitor and as a panel emulator front end for verifying the HUB75 driver chain.

---
 rtl/hub75_pkg.sv | 35 +++
 rtl/hub75_edge_sync.sv | 58 +++++
 rtl/hub75_rx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// ============================================================================
//  Module      : hub75_pkg
//  Description : Shared types and default widths for the HUB75 receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hub75_pkg;

    localparam int unsigned HPIXEL_DEF    = 64;
    localparam int unsigned VPIXEL_DEF    = 64;
    localparam int unsigned SEGMENTS_DEF  = 2;
    localparam int unsigned BPP_DEF       = 8;
    localparam int unsigned ON_CNT_WD_DEF = 20;

    localparam int unsigned ADDR_W  = $clog2(VPIXEL_DEF / SEGMENTS_DEF);
    localparam int unsigned PLANE_W = $clog2(BPP_DEF);
    localparam int unsigned DATA_W  = 3 * SEGMENTS_DEF * HPIXEL_DEF;

    typedef enum logic [1:0] {
        WAIT_HIGH = 2'd0,
        BLANK     = 2'd1,
        ON        = 2'd2
    } hub75_rx_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]        addr;
        logic [PLANE_W-1:0]       plane;
        logic [ON_CNT_WD_DEF-1:0] on_cnt;
        logic [DATA_W-1:0]        data;
    } hub75_evt_t;

endpackage

`default_nettype wire

// File: rtl/hub75_edge_sync.sv
// ============================================================================
//  Module      : hub75_edge_sync
//  Description : One-bit input conditioner with level, rise and fall outputs.
//                HUB75_RX_SYNC_EN selects a 2-flop synchronizer instead of a
//                single input register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hub75_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_sync;
    logic r_dly;

`ifdef HUB75_RX_SYNC_EN
    logic r_meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 1'b0;
        end else begin
            r_sync <= i_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly <= 1'b0;
        end else begin
            r_dly <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_dly;
    assign o_fall  = ~r_sync & r_dly;

endmodule

`default_nettype wire

// File: rtl/hub75_rx.sv
// ============================================================================
//  Module      : hub75_rx
//  Description : HUB75 panel-side receiver: captures latched columns, measures
//                OE-active time, infers bit plane, emits line events.
//                Define HUB75_RX_SYNC_EN for asynchronous HUB75 pins.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hub75_rx
    import hub75_pkg::*;
#(
    parameter int hpixel_p    = 64,
    parameter int vpixel_p    = 64,
    parameter int segments_p  = 2,
    parameter int bpp_p       = 8,
    parameter int on_cnt_wd_p = 20
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_hub_clk,
    input  logic                                   i_hub_lat,
    input  logic                                   i_hub_oe_n,
    input  logic [$clog2(vpixel_p/segments_p)-1:0] i_hub_addr,
    input  logic [3*segments_p-1:0]                i_hub_rgb,
    output logic                                   o_evt_valid,
    input  logic                                   i_evt_ready,
    output logic [$clog2(vpixel_p/segments_p)-1:0] o_evt_addr,
    output logic [$clog2(bpp_p)-1:0]               o_evt_plane,
    output logic [on_cnt_wd_p-1:0]                 o_evt_on_cnt,
    output logic [3*segments_p*hpixel_p-1:0]       o_evt_data,
    output logic                                   o_shift_err,
    output logic                                   o_overrun
);

    localparam int c_ADDR_W  = $clog2(vpixel_p / segments_p);
    localparam int c_PLANE_W = $clog2(bpp_p);
    localparam int c_RGB_W   = 3 * segments_p;
    localparam int c_DATA_W  = 3 * segments_p * hpixel_p;
    localparam int c_SCNT_W  = $clog2(hpixel_p + 2);

    localparam logic [c_PLANE_W-1:0] c_PLANE_MAX = c_PLANE_W'(bpp_p - 1);
    localparam logic [c_SCNT_W-1:0]  c_SCNT_FULL = c_SCNT_W'(hpixel_p);
    localparam logic [c_SCNT_W-1:0]  c_SCNT_SAT  = c_SCNT_W'(hpixel_p + 1);

    logic w_clk_lvl, w_clk_rise, w_clk_fall;
    logic w_lat_lvl, w_lat_rise, w_lat_fall;
    logic w_oe_lvl,  w_oe_rise,  w_oe_fall;
    logic w_unused;

    hub75_edge_sync u_sync_clk (
        .clk(clk), .rst(rst), .i_d(i_hub_clk),
        .o_level(w_clk_lvl), .o_rise(w_clk_rise), .o_fall(w_clk_fall)
    );
    hub75_edge_sync u_sync_lat (
        .clk(clk), .rst(rst), .i_d(i_hub_lat),
        .o_level(w_lat_lvl), .o_rise(w_lat_rise), .o_fall(w_lat_fall)
    );
    hub75_edge_sync u_sync_oe (
        .clk(clk), .rst(rst), .i_d(i_hub_oe_n),
        .o_level(w_oe_lvl), .o_rise(w_oe_rise), .o_fall(w_oe_fall)
    );

    assign w_unused = ^{w_clk_lvl, w_clk_fall, w_lat_lvl, w_lat_fall};

    // Buses get the same flop depth as the edge conditioners so they stay aligned.
    logic [c_RGB_W-1:0]  r_rgb;
    logic [c_ADDR_W-1:0] r_addr;

`ifdef HUB75_RX_SYNC_EN
    logic [c_RGB_W-1:0]  r_rgb_meta;
    logic [c_ADDR_W-1:0] r_addr_meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb_meta  <= '0;
            r_addr_meta <= '0;
            r_rgb       <= '0;
            r_addr      <= '0;
        end else begin
            r_rgb_meta  <= i_hub_rgb;
            r_addr_meta <= i_hub_addr;
            r_rgb       <= r_rgb_meta;
            r_addr      <= r_addr_meta;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb  <= '0;
            r_addr <= '0;
        end else begin
            r_rgb  <= i_hub_rgb;
            r_addr <= i_hub_addr;
        end
    end
`endif

    logic [c_DATA_W-1:0] r_shift, r_latch, w_shift_nxt;
    logic [c_SCNT_W-1:0] r_scnt, w_scnt_nxt;
    logic                r_shift_err;

    always_comb begin
        w_shift_nxt = r_shift;
        w_scnt_nxt  = r_scnt;
        if (w_clk_rise) begin
            w_shift_nxt = {r_rgb, r_shift[c_DATA_W-1:c_RGB_W]};
            if (r_scnt != c_SCNT_SAT) begin
                w_scnt_nxt = r_scnt + c_SCNT_W'(1);
            end
        end
    end

    // A latch in the same cycle as a shift sees the post-shift contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_latch     <= '0;
            r_scnt      <= '0;
            r_shift_err <= 1'b0;
        end else begin
            r_shift <= w_shift_nxt;
            if (w_lat_rise) begin
                r_latch <= w_shift_nxt;
                r_scnt  <= '0;
                if (w_scnt_nxt != c_SCNT_FULL) begin
                    r_shift_err <= 1'b1;
                end
            end else begin
                r_scnt <= w_scnt_nxt;
            end
        end
    end

    hub75_rx_state_e r_state, w_state_nxt;
    logic            w_start, w_run, w_stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_HIGH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_run       = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            WAIT_HIGH: begin
                if (w_oe_lvl) begin
                    w_state_nxt = BLANK;
                end
            end
            BLANK: begin
                if (w_oe_fall) begin
                    w_start     = 1'b1;
                    w_state_nxt = ON;
                end
            end
            ON: begin
                if (w_oe_rise) begin
                    w_stop      = 1'b1;
                    w_state_nxt = BLANK;
                end else begin
                    w_run = 1'b1;
                end
            end
            default: w_state_nxt = WAIT_HIGH;
        endcase
    end

    logic                   r_seen;
    logic [c_ADDR_W-1:0]    r_cap_addr;
    logic [c_PLANE_W-1:0]   r_plane;
    logic [on_cnt_wd_p-1:0] r_on_cnt;
    logic [c_DATA_W-1:0]    r_snap;
    logic                   r_emit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seen     <= 1'b0;
            r_cap_addr <= '0;
            r_plane    <= '0;
            r_on_cnt   <= '0;
            r_snap     <= '0;
            r_emit     <= 1'b0;
        end else begin
            r_emit <= w_stop;
            if (w_start) begin
                r_cap_addr <= r_addr;
                r_snap     <= r_latch;
                r_on_cnt   <= on_cnt_wd_p'(1);
                r_seen     <= 1'b1;
                if (!r_seen || (r_addr != r_cap_addr)) begin
                    r_plane <= '0;
                end else if (r_plane != c_PLANE_MAX) begin
                    r_plane <= r_plane + c_PLANE_W'(1);
                end
            end else if (w_run && (r_on_cnt != '1)) begin
                r_on_cnt <= r_on_cnt + on_cnt_wd_p'(1);
            end
        end
    end

    logic                   r_evt_valid;
    logic [c_ADDR_W-1:0]    r_evt_addr;
    logic [c_PLANE_W-1:0]   r_evt_plane;
    logic [on_cnt_wd_p-1:0] r_evt_on_cnt;
    logic [c_DATA_W-1:0]    r_evt_data;
    logic                   r_overrun;

    // A held event is never overwritten; a new one arriving under backpressure is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_evt_valid  <= 1'b0;
            r_evt_addr   <= '0;
            r_evt_plane  <= '0;
            r_evt_on_cnt <= '0;
            r_evt_data   <= '0;
            r_overrun    <= 1'b0;
        end else if (r_emit) begin
            if (!r_evt_valid || i_evt_ready) begin
                r_evt_valid  <= 1'b1;
                r_evt_addr   <= r_cap_addr;
                r_evt_plane  <= r_plane;
                r_evt_on_cnt <= r_on_cnt;
                r_evt_data   <= r_snap;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (r_evt_valid && i_evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

    assign o_evt_valid  = r_evt_valid;
    assign o_evt_addr   = r_evt_addr;
    assign o_evt_plane  = r_evt_plane;
    assign o_evt_on_cnt = r_evt_on_cnt;
    assign o_evt_data   = r_evt_data;
    assign o_shift_err  = r_shift_err;
    assign o_overrun    = r_overrun;

endmodule

`default_nettype wire
